datapath_mc_param: RTL and testbench

- Parametrised multi-cycle datapath: register file, ALU, B/K operand select, result-select mux and status register.
- Talks to an external variable-latency data memory through a req/ack handshake, with a timeout.
- Accepts one decoded control word per operation over a valid/ready handshake.
- Sits between the control unit (upstream) and the data memory / program counter (downstream). Successor to the fixed 64-bit single-cycle register/ALU datapath.

---
 rtl/dp_mc_pkg.sv | 34 +++
 rtl/alu_param.sv | 43 ++++
 rtl/reg_file_param.sv | 39 +++
 rtl/datapath_mc_param.sv | 167 ++++++++++++++++
 tb/tb_datapath_mc_param.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_mc_pkg.sv
// Shared types and encodings for the multi-cycle datapath: FSM states,
// result-select codes, status width and the ALU function-select map.
package dp_mc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MEM  = 2'd2,
        WB   = 2'd3
    } state_e;

    localparam logic [1:0] SEL_MEM = 2'd0;
    localparam logic [1:0] SEL_ALU = 2'd1;
    localparam logic [1:0] SEL_B   = 2'd2;
    localparam logic [1:0] SEL_PC  = 2'd3;

    localparam int STAT_W = 4;

    // FS[4:2] picks the operation, FS[1] inverts A, FS[0] inverts B and
    // supplies the carry-in, so FS_SUB is A + ~B + 1.
    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_XOR = 3'd3;
    localparam logic [2:0] ALU_SHL = 3'd4;
    localparam logic [2:0] ALU_SHR = 3'd5;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_OR  = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_XOR = 5'b01100;

endpackage

// File: rtl/alu_param.sv
// Shared ALU widened through DATA_W. Status is {V, C, N, Z}; V and C are
// only meaningful for the adder and read 0 for the other operations.
module alu_param
    import dp_mc_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int FS_W   = 5
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [FS_W-1:0]   fs,
    output logic [DATA_W-1:0] f,
    output logic [STAT_W-1:0] status
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic [DATA_W-1:0] sum;
    logic              carry;
    logic              ovf;
    logic              is_add;

    always_comb begin
        a_in         = fs[1] ? ~a : a;
        b_in         = fs[0] ? ~b : b;
        {carry, sum} = {1'b0, a_in} + {1'b0, b_in} + {{DATA_W{1'b0}}, fs[0]};
        ovf          = (a_in[DATA_W-1] == b_in[DATA_W-1]) && (sum[DATA_W-1] != a_in[DATA_W-1]);
        is_add       = (fs[4:2] == ALU_ADD);
        case (fs[4:2])
            ALU_AND: f = a_in & b_in;
            ALU_OR:  f = a_in | b_in;
            ALU_ADD: f = sum;
            ALU_XOR: f = a_in ^ b_in;
            ALU_SHL: f = a << b[SH_W-1:0];
            ALU_SHR: f = a >> b[SH_W-1:0];
            default: f = '0;
        endcase
        status = {ovf & is_add, carry & is_add, f[DATA_W-1], (f == '0)};
    end

endmodule

// File: rtl/reg_file_param.sv
// Register file: two asynchronous read ports, one synchronous write port,
// asynchronous clear. Optionally the top entry is hard-wired to zero.
module reg_file_param #(
    parameter int DATA_W      = 64,
    parameter int RA_W        = 5,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [RA_W-1:0]   wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [RA_W-1:0]   ra_a,
    input  logic [RA_W-1:0]   ra_b,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b
);

    localparam int              NREGS     = 2 ** RA_W;
    localparam logic [RA_W-1:0] ZERO_ADDR = '1;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              wr_en;

    always_comb begin
        wr_en = we && !(ZERO_REG_EN && (wa == ZERO_ADDR));
        rd_a  = (ZERO_REG_EN && (ra_a == ZERO_ADDR)) ? '0 : regs_q[ra_a];
        rd_b  = (ZERO_REG_EN && (ra_b == ZERO_ADDR)) ? '0 : regs_q[ra_b];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[wa] <= wd;
        end
    end

endmodule

// File: rtl/datapath_mc_param.sv
// Multi-cycle datapath: IDLE -> EXEC -> (MEM) -> WB, one control word per
// operation, external memory reached through a req/ack handshake with timeout.
module datapath_mc_param
    import dp_mc_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int RA_W        = 5,
    parameter int FS_W        = 5,
    parameter bit ZERO_REG_EN = 1'b1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    // Control word handshake: a word transfers on a rising edge where
    // cw_valid and cw_ready are both high; cw_ready is high only in IDLE.
    input  logic              cw_valid,
    output logic              cw_ready,
    input  logic [RA_W-1:0]   DA,
    input  logic [RA_W-1:0]   SA,
    input  logic [RA_W-1:0]   SB,
    input  logic [FS_W-1:0]   FS,
    input  logic              regW,
    input  logic              memR,
    input  logic              memW,
    input  logic              selB,
    input  logic [1:0]        selD,
    input  logic              SL,
    input  logic [DATA_W-1:0] K,
    input  logic [DATA_W-1:0] pc_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [3:0]        status_reg,
    output logic              err,
    output logic [1:0]        dbg_state
);

    localparam int             TW      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0]  TO_LAST = TW'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [RA_W-1:0]   da_q, da_d;
    logic [FS_W-1:0]   fs_q, fs_d;
    logic              regw_q, regw_d, memr_q, memr_d, memw_q, memw_d;
    logic              selb_q, selb_d, sl_q, sl_d, abort_q, abort_d, err_q, err_d;
    logic [1:0]        seld_q, seld_d;
    logic [DATA_W-1:0] k_q, k_d, a_q, a_d, b_q, b_d, alu_q, alu_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, dout_q, dout_d;
    logic [STAT_W-1:0] stat_q, stat_d, status_q, status_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;

    logic [DATA_W-1:0] rd_a, rd_b, alu_f, wb_val;
    logic [STAT_W-1:0] alu_stat;
    logic              rf_we;

    reg_file_param #(.DATA_W(DATA_W), .RA_W(RA_W), .ZERO_REG_EN(ZERO_REG_EN)) u_rf (
        .clock(clock), .reset(reset), .we(rf_we), .wa(da_q), .wd(wb_val),
        .ra_a(SA), .ra_b(SB), .rd_a(rd_a), .rd_b(rd_b)
    );

    alu_param #(.DATA_W(DATA_W), .FS_W(FS_W)) u_alu (
        .a(a_q), .b(selb_q ? k_q : b_q), .fs(fs_q), .f(alu_f), .status(alu_stat)
    );

    always_comb begin
        case (seld_q)
            SEL_MEM: wb_val = rdata_q;
            SEL_ALU: wb_val = alu_q;
            SEL_B:   wb_val = b_q;
            default: wb_val = pc_in;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        da_d     = da_q;     fs_d   = fs_q;   regw_d = regw_q;
        memr_d   = memr_q;   memw_d = memw_q; selb_d = selb_q;
        seld_d   = seld_q;   sl_d   = sl_q;   k_d    = k_q;
        a_d      = a_q;      b_d    = b_q;    alu_d  = alu_q;
        stat_d   = stat_q;   rdata_d = rdata_q;
        dout_d   = dout_q;   status_d = status_q;
        abort_d  = abort_q;  err_d  = err_q;  tcnt_d = tcnt_q;
        rf_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cw_valid) begin
                    da_d = DA;     fs_d = FS;     regw_d = regW;
                    memr_d = memR; memw_d = memW; selb_d = selB;
                    seld_d = selD; sl_d = SL;     k_d = K;
                    a_d = rd_a;    b_d = rd_b;    abort_d = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_d  = alu_f;
                stat_d = alu_stat;
                tcnt_d = '0;
                // Simultaneous read and write is a malformed word: flag it and skip memory.
                if (memr_q && memw_q) begin
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                    state_d = WB;
                end else if (memr_q || memw_q) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    if (memr_q) rdata_d = mem_rdata;
                    state_d = WB;
                end else if (tcnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                    state_d = WB;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: begin
                rf_we  = regw_q && !abort_q;
                dout_d = wb_val;
                if (sl_q) status_d = stat_q;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            da_q <= '0;   fs_q <= '0;   regw_q <= 1'b0; memr_q <= 1'b0;
            memw_q <= 1'b0; selb_q <= 1'b0; seld_q <= '0; sl_q <= 1'b0;
            k_q <= '0;    a_q <= '0;    b_q <= '0;    alu_q <= '0;
            stat_q <= '0; rdata_q <= '0; dout_q <= '0; status_q <= '0;
            abort_q <= 1'b0; err_q <= 1'b0; tcnt_q <= '0;
        end else begin
            state_q <= state_d;
            da_q <= da_d;   fs_q <= fs_d;   regw_q <= regw_d; memr_q <= memr_d;
            memw_q <= memw_d; selb_q <= selb_d; seld_q <= seld_d; sl_q <= sl_d;
            k_q <= k_d;     a_q <= a_d;     b_q <= b_d;     alu_q <= alu_d;
            stat_q <= stat_d; rdata_q <= rdata_d; dout_q <= dout_d; status_q <= status_d;
            abort_q <= abort_d; err_q <= err_d; tcnt_q <= tcnt_d;
        end
    end

    // Memory outputs are gated by state so they fall with the asynchronous reset.
    always_comb begin
        cw_ready   = (state_q == IDLE);
        mem_req    = (state_q == MEM);
        mem_we     = mem_req && memw_q;
        mem_addr   = mem_req ? alu_q : '0;
        mem_wdata  = mem_req ? b_q : '0;
        data_valid = (state_q == WB);
        data_out   = data_valid ? wb_val : dout_q;
        status_reg = status_q;
        err        = err_q;
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_datapath_mc_param.sv
// Self-checking bench for datapath_mc_param: scoreboard of expected data_out
// values, a small register model, and directed memory/timeout/reset cases.
module tb_datapath_mc_param;
    import dp_mc_pkg::*;

    localparam int DW = 64;
    localparam int TO = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cw_valid = 1'b0, cw_ready;
    logic [4:0]    DA = '0, SA = '0, SB = '0, FS = '0;
    logic          regW = 1'b0, memR = 1'b0, memW = 1'b0, selB = 1'b0, SL = 1'b0;
    logic [1:0]    selD = '0;
    logic [DW-1:0] K = '0, pc_in = '0;
    logic          mem_req, mem_we, mem_ack = 1'b0;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata = '0, data_out;
    logic          data_valid, err;
    logic [3:0]    status_reg;
    logic [1:0]    dbg_state;

    datapath_mc_param #(.DATA_W(DW), .RA_W(5), .FS_W(5), .ZERO_REG_EN(1'b1), .MEM_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .cw_valid(cw_valid), .cw_ready(cw_ready),
        .DA(DA), .SA(SA), .SB(SB), .FS(FS), .regW(regW), .memR(memR), .memW(memW),
        .selB(selB), .selD(selD), .SL(SL), .K(K), .pc_in(pc_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .data_out(data_out),
        .data_valid(data_valid), .status_reg(status_reg), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard / model ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_r [32];
    int            n_checks = 0;
    int            n_errors = 0;

    // observations of the most recent operation
    int            req_cycles, ready_low, dv_cyc;
    logic [DW-1:0] first_addr, first_wdata;
    logic          first_we, addr_stable;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_cw(input logic [4:0] da, sa, sb, fs, input logic regw, memr, memw,
                            selb, input logic [1:0] seld, input logic sl, input logic [DW-1:0] k);
        @(negedge clock);
        DA = da; SA = sa; SB = sb; FS = fs; regW = regw; memR = memr; memW = memw;
        selB = selb; selD = seld; SL = sl; K = k; cw_valid = 1'b1;
        @(posedge clock);
        #1 cw_valid = 1'b0;
    endtask

    // Runs one operation; ack_after = n acks in the n-th request cycle, 0 = never.
    task automatic do_op(input string tag, input logic [4:0] da, sa, sb, fs,
                         input logic regw, memr, memw, selb, input logic [1:0] seld,
                         input logic sl, input logic [DW-1:0] k, input int ack_after,
                         input logic [DW-1:0] rdata, input logic [DW-1:0] exp, input logic exp_wr);
        logic [DW-1:0] got;
        got = '0;
        exp_q.push_back(exp);
        drive_cw(da, sa, sb, fs, regw, memr, memw, selb, seld, sl, k);
        req_cycles = 0; ready_low = 0; dv_cyc = 0; addr_stable = 1'b1;
        first_addr = '0; first_wdata = '0; first_we = 1'b0;
        for (int cyc = 1; cyc <= 30 && dv_cyc == 0; cyc++) begin
            @(negedge clock);
            if (!cw_ready) ready_low++;
            if (mem_req) begin
                if (req_cycles == 0) begin
                    first_addr = mem_addr; first_wdata = mem_wdata; first_we = mem_we;
                end else if (mem_addr !== first_addr || mem_wdata !== first_wdata) begin
                    addr_stable = 1'b0;
                end
                req_cycles++;
                if (req_cycles == ack_after) begin
                    mem_ack = 1'b1; mem_rdata = rdata;
                end else begin
                    mem_ack = 1'b0;
                end
            end else begin
                mem_ack = 1'b0;
            end
            if (data_valid) begin
                dv_cyc = cyc; got = data_out;
            end
        end
        mem_ack = 1'b0;
        if (dv_cyc == 0) check({tag, "_dv_timeout"}, 64'd0, 64'd1);
        else             check(tag, got, exp_q.pop_front());
        @(negedge clock);
        check({tag, "_dv_pulse"}, {63'd0, data_valid}, 64'd0);
        if (exp_wr && da != 5'd31) model_r[da] = exp;
    endtask

    task automatic load_imm(input logic [4:0] da, input logic [DW-1:0] k);
        do_op("load_imm", da, 5'd31, 5'd0, FS_ADD, 1'b1, 1'b0, 1'b0, 1'b1, SEL_ALU, 1'b0, k, 0, '0, k, 1'b1);
    endtask

    task automatic read_reg(input logic [4:0] idx);
        do_op($sformatf("R%0d", idx), 5'd0, 5'd0, idx, FS_ADD, 1'b0, 1'b0, 1'b0, 1'b0, SEL_B, 1'b0, '0,
              0, '0, model_r[idx], 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] ra, rb, ex;
        logic [4:0]    fsel;
        int            pick;
        bit            hit;

        for (int i = 0; i < 32; i++) model_r[i] = '0;
        repeat (3) @(negedge clock);
        check("rst_cw_ready", {63'd0, cw_ready}, 64'd1);
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_data_out", data_out, 64'd0);
        check("rst_status", {60'd0, status_reg}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        reset = 1'b1;

        // ALU add with status load
        load_imm(5'd1, 64'd5);
        load_imm(5'd2, 64'd7);
        do_op("add", 5'd3, 5'd1, 5'd2, FS_ADD, 1'b1, 1'b0, 1'b0, 1'b0, SEL_ALU, 1'b1, '0, 0, '0, 64'd12, 1'b1);
        check("add_latency", 64'(dv_cyc), 64'd2);
        check("add_ready_low", 64'(ready_low), 64'd2);
        check("add_status", {60'd0, status_reg}, 64'h0);
        read_reg(5'd3);

        // immediate + zero register
        do_op("zero_add", 5'd4, 5'd31, 5'd0, FS_ADD, 1'b1, 1'b0, 1'b0, 1'b1, SEL_ALU, 1'b1, '0, 0, '0, 64'd0, 1'b1);
        check("zero_status", {60'd0, status_reg}, 64'h1);
        load_imm(5'd31, 64'hFF);
        read_reg(5'd31);

        // subtract: 5 - 7, negative, no carry out
        do_op("sub", 5'd5, 5'd1, 5'd2, FS_SUB, 1'b1, 1'b0, 1'b0, 1'b0, SEL_ALU, 1'b1, '0, 0, '0,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        check("sub_status", {60'd0, status_reg}, 64'h2);

        // random register-register operations
        for (int n = 0; n < 4; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            load_imm(5'd20, ra);
            load_imm(5'd21, rb);
            pick = $urandom_range(0, 3);
            case (pick)
                0:       begin fsel = FS_ADD; ex = ra + rb; end
                1:       begin fsel = FS_SUB; ex = ra - rb; end
                2:       begin fsel = FS_AND; ex = ra & rb; end
                default: begin fsel = FS_XOR; ex = ra ^ rb; end
            endcase
            do_op("rand_alu", 5'd22, 5'd20, 5'd21, fsel, 1'b1, 1'b0, 1'b0, 1'b0, SEL_ALU, 1'b0, '0, 0, '0, ex, 1'b1);
        end
        read_reg(5'd22);

        // pc_in select
        pc_in = {$urandom, $urandom};
        do_op("pc_sel", 5'd14, 5'd0, 5'd0, FS_ADD, 1'b1, 1'b0, 1'b0, 1'b0, SEL_PC, 1'b0, '0, 0, '0, pc_in, 1'b1);
        read_reg(5'd14);

        // load with a 4-cycle wait
        load_imm(5'd6, 64'h40);
        do_op("load", 5'd7, 5'd6, 5'd0, FS_ADD, 1'b1, 1'b1, 1'b0, 1'b1, SEL_MEM, 1'b0, '0, 4, 64'hDEAD,
              64'hDEAD, 1'b1);
        check("load_req_cycles", 64'(req_cycles), 64'd4);
        check("load_addr", first_addr, 64'h40);
        check("load_addr_stable", {63'd0, addr_stable}, 64'd1);
        check("load_we", {63'd0, first_we}, 64'd0);
        read_reg(5'd7);

        // store: address R9+K, data is R8 not K
        load_imm(5'd8, 64'h1234);
        load_imm(5'd9, 64'h100);
        do_op("store", 5'd10, 5'd9, 5'd8, FS_ADD, 1'b0, 1'b0, 1'b1, 1'b1, SEL_ALU, 1'b0, 64'd8, 1, '0,
              64'h108, 1'b0);
        check("store_we", {63'd0, first_we}, 64'd1);
        check("store_wdata", first_wdata, 64'h1234);
        check("store_addr", first_addr, 64'h108);
        check("store_req_cycles", 64'(req_cycles), 64'd1);
        read_reg(5'd10);

        // ack in the very last allowed MEM cycle still succeeds
        do_op("load_edge", 5'd11, 5'd6, 5'd0, FS_ADD, 1'b1, 1'b1, 1'b0, 1'b1, SEL_MEM, 1'b0, '0, TO,
              64'hBEEF, 64'hBEEF, 1'b1);
        check("edge_err", {63'd0, err}, 64'd0);
        read_reg(5'd11);

        // read and write together: error, no memory access, no write, status still loads
        load_imm(5'd12, 64'h77);
        do_op("both_rw", 5'd12, 5'd1, 5'd0, FS_ADD, 1'b1, 1'b1, 1'b1, 1'b1, SEL_ALU, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFB, 0, '0, 64'd0, 1'b0);
        check("both_req_cycles", 64'(req_cycles), 64'd0);
        check("both_err", {63'd0, err}, 64'd1);
        check("both_status", {60'd0, status_reg}, 64'h5);
        read_reg(5'd12);

        // reset in the middle of a memory access
        drive_cw(5'd7, 5'd6, 5'd0, FS_ADD, 1'b1, 1'b1, 1'b0, 1'b1, SEL_MEM, 1'b0, '0);
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(negedge clock);
            hit = mem_req;
        end
        check("rst_mid_reach_mem", {63'd0, hit}, 64'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_mid_err", {63'd0, err}, 64'd0);
        check("rst_mid_status", {60'd0, status_reg}, 64'd0);
        check("rst_mid_data_out", data_out, 64'd0);
        for (int i = 0; i < 32; i++) model_r[i] = '0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_cw_ready", {63'd0, cw_ready}, 64'd1);
        check("rst_mid_state", {62'd0, dbg_state}, 64'd0);
        read_reg(5'd1);
        read_reg(5'd7);

        // memory timeout with no ack
        load_imm(5'd6, 64'h40);
        load_imm(5'd13, 64'h99);
        do_op("timeout", 5'd13, 5'd6, 5'd0, FS_ADD, 1'b1, 1'b1, 1'b0, 1'b1, SEL_ALU, 1'b0, '0, 0, '0,
              64'h40, 1'b0);
        check("timeout_req_cycles", 64'(req_cycles), 64'(TO));
        check("timeout_err", {63'd0, err}, 64'd1);
        read_reg(5'd13);

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
